uart_cfg: RTL

Parametrised full-duplex UART replacing the fixed 8N1, 4x-oversampled UART. Adds:
- configurable data width, parity and stop bits;
- a 16x-oversampled, metastability-hardened receiver;
- an RX FIFO with per-entry error tags;
- valid/ready handshakes on both byte paths.

It sits between the bus-side register interface and the board serial pins.

---
 rtl/uart_cfg.sv | 215 +++++++++++++++++++++
 1 files changed

// File: rtl/uart_cfg.sv
// rtl/uart_cfg.sv - parametrised full-duplex UART: oversampled RX, error-tagged RX FIFO, handshaked TX
module uart_cfg #(
    parameter int CLK_DIV    = 326,
    parameter int OVERSAMPLE = 16,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        rx,
    output logic                        tx,
    input  logic                        tx_valid,
    output logic                        tx_ready,
    input  logic [DATA_BITS-1:0]        tx_data,
    output logic                        rx_valid,
    input  logic                        rx_ready,
    output logic [DATA_BITS-1:0]        rx_data,
    output logic                        rx_parity_err,
    output logic                        rx_frame_err,
    output logic                        rx_overrun,
    output logic [$clog2(FIFO_DEPTH):0] rx_level,
    output logic                        rx_busy,
    output logic                        tx_busy
);
    localparam int OSW = $clog2(OVERSAMPLE);
    localparam int AW  = $clog2(FIFO_DEPTH);
    localparam logic [15:0]    DIV_LAST  = 16'(CLK_DIV - 1);
    localparam logic [OSW-1:0] OS_LAST   = OSW'(OVERSAMPLE - 1);
    localparam logic [OSW-1:0] OS_MID    = OSW'(OVERSAMPLE / 2 - 1);
    localparam logic [2:0]     BIT_LAST  = 3'(DATA_BITS - 1);
    localparam logic           STOP_LAST = 1'(STOP_BITS - 1);
    localparam logic           ODD       = (PARITY == 1);
    localparam logic [AW:0]    FULL_LVL  = (AW + 1)'(FIFO_DEPTH);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_PARITY = 3'd3;
    localparam logic [2:0] S_STOP   = 3'd4;

    logic                 rx_meta, rx_sync, rx_prev;
    logic [15:0]          rx_div;
    logic [OSW-1:0]       rx_os;
    logic [2:0]           rx_state, rx_bit;
    logic [DATA_BITS-1:0] rx_shift;
    logic                 rx_perr, rx_tick, rx_bit_end;
    logic                 push, push_ok, pop, full, overrun;
    logic [DATA_BITS+1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]        wr_ptr, rd_ptr;
    logic [AW:0]          level;

    assign rx_tick    = (rx_div == DIV_LAST);
    // The start bit is judged half a bit in; every later sample is a full bit apart.
    assign rx_bit_end = rx_tick && (rx_os == ((rx_state == S_START) ? OS_MID : OS_LAST));
    assign push       = rx_bit_end && (rx_state == S_STOP);
    assign rx_busy    = (rx_state != S_IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta  <= 1'b1;
            rx_sync  <= 1'b1;
            rx_prev  <= 1'b1;
            rx_div   <= '0;
            rx_os    <= '0;
            rx_state <= S_IDLE;
            rx_bit   <= '0;
            rx_shift <= '0;
            rx_perr  <= 1'b0;
        end else begin
            rx_meta <= rx;
            rx_sync <= rx_meta;
            rx_prev <= rx_sync;
            rx_div  <= rx_tick ? '0 : rx_div + 16'd1;
            if (rx_tick)
                rx_os <= rx_bit_end ? '0 : rx_os + 1'b1;
            case (rx_state)
                S_IDLE: begin
                    // Needs a genuine falling edge, so a line stuck low after a bad stop never re-arms.
                    if (rx_prev && !rx_sync) begin
                        rx_state <= S_START;
                        rx_div   <= '0;
                        rx_os    <= '0;
                        rx_perr  <= 1'b0;
                    end
                end
                S_START: if (rx_bit_end) begin
                    rx_state <= rx_sync ? S_IDLE : S_DATA;
                    rx_bit   <= '0;
                end
                S_DATA: if (rx_bit_end) begin
                    rx_shift <= {rx_sync, rx_shift[DATA_BITS-1:1]};
                    rx_bit   <= rx_bit + 3'd1;
                    if (rx_bit == BIT_LAST)
                        rx_state <= (PARITY != 0) ? S_PARITY : S_STOP;
                end
                S_PARITY: if (rx_bit_end) begin
                    rx_perr  <= rx_sync ^ (^rx_shift) ^ ODD;
                    rx_state <= S_STOP;
                end
                S_STOP: if (rx_bit_end)
                    rx_state <= S_IDLE;
                default: rx_state <= S_IDLE;
            endcase
        end
    end

    assign rx_valid   = (level != '0);
    assign pop        = rx_valid && rx_ready;
    assign full       = (level == FULL_LVL);
    assign push_ok    = push && (!full || pop);
    assign rx_level   = level;
    assign rx_overrun = overrun;
    assign {rx_data, rx_parity_err, rx_frame_err} = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push_ok && !rst)
            mem[wr_ptr] <= {rx_shift, rx_perr, !rx_sync};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level   <= '0;
            overrun <= 1'b0;
        end else begin
            if (push_ok)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            if (push_ok && !pop)
                level <= level + 1'b1;
            else if (!push_ok && pop)
                level <= level - 1'b1;
            if (pop)
                overrun <= 1'b0;
            else if (push && full)
                overrun <= 1'b1;
        end
    end

    logic [15:0]          tx_div;
    logic [OSW-1:0]       tx_os;
    logic [2:0]           tx_state, tx_bit;
    logic                 tx_stop, tx_par, tx_tick, tx_bit_end;
    logic [DATA_BITS-1:0] tx_shift;

    assign tx_tick    = (tx_div == DIV_LAST);
    assign tx_bit_end = tx_tick && (tx_os == OS_LAST);
    assign tx_ready   = (tx_state == S_IDLE);
    assign tx_busy    = !tx_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            tx       <= 1'b1;
            tx_state <= S_IDLE;
            tx_div   <= '0;
            tx_os    <= '0;
            tx_bit   <= '0;
            tx_stop  <= 1'b0;
            tx_par   <= 1'b0;
            tx_shift <= '0;
        end else begin
            tx_div <= tx_tick ? '0 : tx_div + 16'd1;
            if (tx_tick)
                tx_os <= tx_os + 1'b1;
            case (tx_state)
                S_IDLE: begin
                    tx <= 1'b1;
                    if (tx_valid) begin
                        tx_shift <= tx_data;
                        tx_par   <= (^tx_data) ^ ODD;
                        tx       <= 1'b0;
                        tx_state <= S_START;
                        tx_div   <= '0;
                        tx_os    <= '0;
                    end
                end
                S_START: if (tx_bit_end) begin
                    tx       <= tx_shift[0];
                    tx_bit   <= '0;
                    tx_state <= S_DATA;
                end
                S_DATA: if (tx_bit_end) begin
                    tx_shift <= tx_shift >> 1;
                    tx_bit   <= tx_bit + 3'd1;
                    if (tx_bit != BIT_LAST) begin
                        tx <= tx_shift[1];
                    end else if (PARITY != 0) begin
                        tx       <= tx_par;
                        tx_state <= S_PARITY;
                    end else begin
                        tx       <= 1'b1;
                        tx_stop  <= 1'b0;
                        tx_state <= S_STOP;
                    end
                end
                S_PARITY: if (tx_bit_end) begin
                    tx       <= 1'b1;
                    tx_stop  <= 1'b0;
                    tx_state <= S_STOP;
                end
                S_STOP: if (tx_bit_end) begin
                    if (tx_stop == STOP_LAST)
                        tx_state <= S_IDLE;
                    else
                        tx_stop <= 1'b1;
                end
                default: tx_state <= S_IDLE;
            endcase
        end
    end
endmodule
